snes_video_pipe: RTL and testbench



---
 rtl/snes_video_pkg.sv | 26 ++
 rtl/snes_pos_counter.sv | 62 ++++++
 rtl/snes_video_pipe.sv | 169 ++++++++++++++++
 tb/tb_snes_video_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/snes_video_pkg.sv
// ============================================================================
// snes_video_pkg : shared constants and types for the SNES video pipe
// Rev 1.0
// ============================================================================
`default_nettype none

package snes_video_pkg;

  localparam logic [7:0] INIDISP_ADDR = 8'h00;
  localparam int         FBLANK_BIT   = 7;

  localparam int OSD_X1_DEF      = 16;
  localparam int OSD_X2_DEF      = 240;
  localparam int OSD_Y1_NTSC_DEF = 160;
  localparam int OSD_Y2_NTSC_DEF = 208;
  localparam int OSD_Y1_PAL_DEF  = 184;
  localparam int OSD_Y2_PAL_DEF  = 232;

  typedef struct packed {
    logic [8:0] hcnt;
    logic [8:0] vcnt;
  } pos_t;

endpackage

`default_nettype wire

// File: rtl/snes_pos_counter.sv
// ============================================================================
// snes_pos_counter : dot/line beam position derived from HBLANK/VBLANK
// Rev 1.0
// ============================================================================
`default_nettype none

module snes_pos_counter
  import snes_video_pkg::*;
#(
  parameter int PIXDIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hblank,
  input  logic vblank,
  output pos_t pos
);

  localparam int DW = (PIXDIV > 1) ? $clog2(PIXDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIXDIV - 1);

  logic [DW-1:0] pixdiv;
  logic          hblank_q;
  logic [8:0]    hcnt;
  logic [8:0]    vcnt;
  logic          wrap;
  logic          hb_rise;

  assign wrap    = (pixdiv == DIV_LAST);
  assign hb_rise = hblank && !hblank_q;

  // VBLANK overrides everything, including a coincident HBLANK rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixdiv   <= '0;
      hblank_q <= 1'b0;
      hcnt     <= '0;
      vcnt     <= '0;
    end else begin
      hblank_q <= hblank;
      if (vblank) begin
        pixdiv <= '0;
        hcnt   <= '0;
        vcnt   <= '0;
      end else begin
        pixdiv <= wrap ? '0 : pixdiv + 1'b1;
        if (hb_rise) begin
          hcnt <= '0;
          if (vcnt != '1) vcnt <= vcnt + 1'b1;
        end else if (!hblank && wrap && hcnt != '1) begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  assign pos.hcnt = hcnt;
  assign pos.vcnt = vcnt;

endmodule

`default_nettype wire

// File: rtl/snes_video_pipe.sv
// ============================================================================
// snes_video_pipe : INIDISP snoop, OSD dim window and brightness scaling
//                   from PPU colour taps to the RGB DAC words
// Rev 1.0
// ============================================================================
`default_nettype none

module snes_video_pipe
  import snes_video_pkg::*;
#(
  parameter int IN_W        = 5,
  parameter int BRI_W       = 4,
  parameter int OUT_W       = 9,
  parameter int PIXDIV      = 4,
  parameter int OSD_X1      = OSD_X1_DEF,
  parameter int OSD_X2      = OSD_X2_DEF,
  parameter int OSD_Y1_NTSC = OSD_Y1_NTSC_DEF,
  parameter int OSD_Y2_NTSC = OSD_Y2_NTSC_DEF,
  parameter int OSD_Y1_PAL  = OSD_Y1_PAL_DEF,
  parameter int OSD_Y2_PAL  = OSD_Y2_PAL_DEF,
  parameter int OSD_SHIFT   = 2
) (
  input  logic             CLK_i,
  input  logic             NRST_i,
  input  logic             PAL_i,
  input  logic             PAWR_i,
  input  logic [7:0]       PADDR_i,
  input  logic [7:0]       PDATA_i,
  input  logic             HBLANK_i,
  input  logic             VBLANK_i,
  input  logic [IN_W-1:0]  R_i,
  input  logic [IN_W-1:0]  G_i,
  input  logic [IN_W-1:0]  B_i,
  input  logic             OSD_EN_i,
  output logic [OUT_W-1:0] R_o,
  output logic [OUT_W-1:0] G_o,
  output logic [OUT_W-1:0] B_o,
  output logic             BLANK_o,
  output logic             IN_OSD_o,
  output logic [8:0]       HCNT_o,
  output logic [8:0]       VCNT_o
);

  localparam int PW = IN_W + BRI_W;

  localparam logic [8:0] X1  = 9'(OSD_X1);
  localparam logic [8:0] X2  = 9'(OSD_X2);
  localparam logic [8:0] Y1N = 9'(OSD_Y1_NTSC);
  localparam logic [8:0] Y2N = 9'(OSD_Y2_NTSC);
  localparam logic [8:0] Y1P = 9'(OSD_Y1_PAL);
  localparam logic [8:0] Y2P = 9'(OSD_Y2_PAL);

  // ---------------------------------------------------------------- snoop
  logic             pawr_q;
  logic [BRI_W-1:0] bri;
  logic             fblank;
  logic             pawr_fall;
  logic             unused_pdata;

  assign pawr_fall    = pawr_q && !PAWR_i;
  assign unused_pdata = ^PDATA_i;

  always_ff @(posedge CLK_i) begin
    if (!NRST_i) begin
      pawr_q <= 1'b1;
      bri    <= '1;
      fblank <= 1'b0;
    end else begin
      pawr_q <= PAWR_i;
      if (pawr_fall && PADDR_i == INIDISP_ADDR) begin
        bri    <= PDATA_i[BRI_W-1:0];
        fblank <= PDATA_i[FBLANK_BIT];
      end
    end
  end

  // ------------------------------------------------------------- position
  pos_t pos;

  snes_pos_counter #(
    .PIXDIV (PIXDIV)
  ) u_pos (
    .clk    (CLK_i),
    .rst_n  (NRST_i),
    .hblank (HBLANK_i),
    .vblank (VBLANK_i),
    .pos    (pos)
  );

  assign HCNT_o = pos.hcnt;
  assign VCNT_o = pos.vcnt;

  // --------------------------------------------------------------- window
  logic [8:0] y1;
  logic [8:0] y2;
  logic       win;

  always_comb begin
    y1  = PAL_i ? Y1P : Y1N;
    y2  = PAL_i ? Y2P : Y2N;
    win = OSD_EN_i && (pos.hcnt > X1) && (pos.hcnt <= X2) &&
          (pos.vcnt > y1) && (pos.vcnt <= y2);
  end

  // -------------------------------------------------------------- stage 1
  logic [IN_W-1:0]  r_s1, g_s1, b_s1;
  logic [BRI_W-1:0] bri_s1;
  logic             win_s1;
  logic             blk_s1;

  always_ff @(posedge CLK_i) begin
    if (!NRST_i) begin
      r_s1   <= '0;
      g_s1   <= '0;
      b_s1   <= '0;
      bri_s1 <= '0;
      win_s1 <= 1'b0;
      blk_s1 <= 1'b0;
    end else begin
      r_s1   <= win ? (R_i >> OSD_SHIFT) : R_i;
      g_s1   <= win ? (G_i >> OSD_SHIFT) : G_i;
      b_s1   <= win ? (B_i >> OSD_SHIFT) : B_i;
      bri_s1 <= bri;
      win_s1 <= win;
      blk_s1 <= fblank || HBLANK_i || VBLANK_i;
    end
  end

  // -------------------------------------------------------------- stage 2
  logic [PW-1:0]    p_r, p_g, p_b;
  logic [OUT_W-1:0] s_r, s_g, s_b;

  assign p_r = PW'(r_s1) * PW'(bri_s1);
  assign p_g = PW'(g_s1) * PW'(bri_s1);
  assign p_b = PW'(b_s1) * PW'(bri_s1);

  generate
    if (OUT_W >= PW) begin : g_wide
      assign s_r = OUT_W'(p_r);
      assign s_g = OUT_W'(p_g);
      assign s_b = OUT_W'(p_b);
    end else begin : g_narrow
      logic unused_lsb;
      assign s_r = p_r[PW-1 -: OUT_W];
      assign s_g = p_g[PW-1 -: OUT_W];
      assign s_b = p_b[PW-1 -: OUT_W];
      assign unused_lsb = ^{p_r[PW-OUT_W-1:0], p_g[PW-OUT_W-1:0], p_b[PW-OUT_W-1:0]};
    end
  endgenerate

  always_ff @(posedge CLK_i) begin
    if (!NRST_i) begin
      R_o      <= '0;
      G_o      <= '0;
      B_o      <= '0;
      BLANK_o  <= 1'b0;
      IN_OSD_o <= 1'b0;
    end else begin
      R_o      <= blk_s1 ? '0 : s_r;
      G_o      <= blk_s1 ? '0 : s_g;
      B_o      <= blk_s1 ? '0 : s_b;
      BLANK_o  <= blk_s1;
      IN_OSD_o <= win_s1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_snes_video_pipe.sv
// ============================================================================
// tb_snes_video_pipe : directed checks of snes_video_pipe (default + OUT_W=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_snes_video_pipe;

  logic       clk = 1'b0;
  logic       nrst, pal, pawr, hblank, vblank, osd_en;
  logic [7:0] paddr, pdata;
  logic [4:0] r_in, g_in, b_in;

  logic [8:0] r_o, g_o, b_o, hcnt, vcnt;
  logic       blank_o, in_osd;
  logic [7:0] r8, g8, b8;
  logic [8:0] hcnt8, vcnt8;
  logic       blank8, in_osd8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snes_video_pipe dut (
    .CLK_i(clk), .NRST_i(nrst), .PAL_i(pal), .PAWR_i(pawr),
    .PADDR_i(paddr), .PDATA_i(pdata), .HBLANK_i(hblank), .VBLANK_i(vblank),
    .R_i(r_in), .G_i(g_in), .B_i(b_in), .OSD_EN_i(osd_en),
    .R_o(r_o), .G_o(g_o), .B_o(b_o), .BLANK_o(blank_o), .IN_OSD_o(in_osd),
    .HCNT_o(hcnt), .VCNT_o(vcnt)
  );

  snes_video_pipe #(.OUT_W(8)) dut8 (
    .CLK_i(clk), .NRST_i(nrst), .PAL_i(pal), .PAWR_i(pawr),
    .PADDR_i(paddr), .PDATA_i(pdata), .HBLANK_i(hblank), .VBLANK_i(vblank),
    .R_i(r_in), .G_i(g_in), .B_i(b_in), .OSD_EN_i(osd_en),
    .R_o(r8), .G_o(g8), .B_o(b8), .BLANK_o(blank8), .IN_OSD_o(in_osd8),
    .HCNT_o(hcnt8), .VCNT_o(vcnt8)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Single-cycle strobe; returns after the 3rd edge following the fall.
  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    paddr = a;
    pdata = d;
    pawr  = 1'b0;
    tick();
    pawr  = 1'b1;
    tick(2);
  endtask

  task automatic wait_hcnt(input int target, input string tag);
    int n;
    n = 0;
    while (hcnt != 9'(target) && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(hcnt), 32'(target));
  endtask

  initial begin
    nrst = 1'b0; pal = 1'b0; pawr = 1'b1; hblank = 1'b0; vblank = 1'b0;
    osd_en = 1'b0; paddr = 8'hFF; pdata = 8'h00;
    r_in = 5'd0; g_in = 5'd0; b_in = 5'd0;
    tick(2);
    chk("rst_r", 32'(r_o), 0);
    chk("rst_blank", 32'(blank_o), 0);
    chk("rst_osd", 32'(in_osd), 0);
    chk("rst_hcnt", 32'(hcnt), 0);
    chk("rst_vcnt", 32'(vcnt), 0);

    // Full brightness after reset, 2-cycle latency
    nrst = 1'b1; r_in = 5'd31; g_in = 5'd31; b_in = 5'd31;
    tick();
    chk("lat1_r", 32'(r_o), 0);
    tick();
    chk("lat2_r", 32'(r_o), 465);
    chk("lat2_blank", 32'(blank_o), 0);
    chk("w8_g_465", 32'(g8), 232);

    // Held-low strobe: capture bri=8 once, later data must be ignored
    paddr = 8'h00; pdata = 8'h08; pawr = 1'b0;
    tick();
    pdata = 8'h03;
    chk("bri_e0", 32'(r_o), 465);
    tick();
    chk("bri_e1", 32'(r_o), 465);
    tick();
    chk("bri_e2", 32'(r_o), 248);
    chk("w8_bri8", 32'(g8), 124);
    tick(2);
    chk("bri_once", 32'(r_o), 248);
    pawr = 1'b1;
    tick();

    // Forced blank, ignored foreign address, then restore
    write_reg(8'h00, 8'h8F);
    chk("fb_blank", 32'(blank_o), 1);
    chk("fb_r", 32'(r_o), 0);
    write_reg(8'h01, 8'h00);
    chk("other_addr", 32'(blank_o), 1);
    write_reg(8'h00, 8'h0F);
    chk("unblank", 32'(blank_o), 0);
    chk("unblank_r", 32'(r_o), 465);

    // Beam position
    vblank = 1'b1;
    tick();
    chk("vb_hcnt", 32'(hcnt), 0);
    chk("vb_vcnt", 32'(vcnt), 0);
    vblank = 1'b0;
    tick(8);
    chk("pix8_hcnt", 32'(hcnt), 2);
    tick(4);
    hblank = 1'b1;
    tick();
    chk("hb_hcnt", 32'(hcnt), 0);
    chk("hb_vcnt", 32'(vcnt), 1);
    tick(3);
    chk("hb_hold_vcnt", 32'(vcnt), 1);
    chk("hb_blank", 32'(blank_o), 1);
    hblank = 1'b0;
    tick(4);
    chk("hb_after", 32'(hcnt), 1);
    vblank = 1'b1; hblank = 1'b1;
    tick();
    chk("vb_hb_vcnt", 32'(vcnt), 0);
    vblank = 1'b0; hblank = 1'b0;
    tick();
    hblank = 1'b1;
    tick();
    hblank = 1'b0;
    tick(3);

    // Mid-frame reset
    nrst = 1'b0;
    tick();
    chk("mrst_vcnt", 32'(vcnt), 0);
    chk("mrst_hcnt", 32'(hcnt), 0);
    nrst = 1'b1;
    tick(4);
    chk("mrst_restart", 32'(hcnt), 1);

    // Walk to line 170, column 100
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    for (int l = 0; l < 170; l++) begin
      hblank = 1'b1;
      tick();
      hblank = 1'b0;
      tick();
    end
    chk("line170", 32'(vcnt), 170);
    wait_hcnt(100, "col100");

    r_in = 5'd31; g_in = 5'd31; b_in = 5'd3; osd_en = 1'b1; pal = 1'b0;
    tick(2);
    chk("ntsc_osd", 32'(in_osd), 1);
    chk("ntsc_g", 32'(g_o), 105);
    chk("ntsc_b_zero", 32'(b_o), 0);
    chk("w8_ntsc_g", 32'(g8), 52);
    pal = 1'b1;
    tick(2);
    chk("pal_osd", 32'(in_osd), 0);
    chk("pal_g", 32'(g_o), 465);

    // Column boundary at X2 (inclusive)
    pal = 1'b0;
    wait_hcnt(240, "col240");
    tick(2);
    chk("x2_in", 32'(in_osd), 1);
    wait_hcnt(241, "col241");
    tick(2);
    chk("x2_out", 32'(in_osd), 0);
    chk("x2_out_g", 32'(g_o), 465);

    // Zero brightness
    write_reg(8'h00, 8'h00);
    chk("bri0_r", 32'(r_o), 0);
    chk("bri0_blank", 32'(blank_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
